// File: rtl/hard_frame_chunk_tx.sv
// Streams one decoded hard-decision frame into the error-bit counter as N-bit chunks
// and collects per-frame and cumulative error statistics.
module hard_frame_chunk_tx #(
  parameter int unsigned VN_NUM           = 7650,
  parameter int unsigned N                = 850,
  parameter int unsigned ROW_CHUNK_NUM    = 9,
  parameter int unsigned PIPELINE_DEPTH   = 5,
  parameter int unsigned SYN_LATENCY      = 2,
  parameter int unsigned TIMEOUT          = 64,
  parameter int unsigned ERR_BIT_BITWIDTH = $clog2(VN_NUM)
) (
  input  logic                        eval_clk,
  input  logic                        rstn,
  input  logic                        frame_start,
  input  logic [VN_NUM-1:0]           frame_in,
  input  logic                        clear_stats,
  output logic [N-1:0]                hard_frame,
  output logic                        en,
  input  logic [ERR_BIT_BITWIDTH-1:0] err_count_in,
  input  logic                        count_done_in,
  output logic                        frame_ready,
  output logic                        result_valid,
  output logic [ERR_BIT_BITWIDTH-1:0] err_total,
  output logic [31:0]                 total_err_bits,
  output logic [15:0]                 err_frame_cnt,
  output logic                        timeout_err
);

  localparam int unsigned EN_CYCLES = PIPELINE_DEPTH + ROW_CHUNK_NUM - 2;
  localparam int unsigned SC_W      = $clog2(EN_CYCLES + 1);
  localparam int unsigned WC_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned RC_W      = $clog2(SYN_LATENCY + 1);

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(EN_CYCLES);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(SYN_LATENCY - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_STREAM    = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_REPORT    = 3'd4;

  logic [2:0]        state;
  logic              fs_q;
  logic              start_pend;
  logic [VN_NUM-1:0] shadow;
  logic [SC_W-1:0]   sc;
  logic [WC_W-1:0]   wc;
  logic [RC_W-1:0]   rc;
  logic              timeout_hit;
  logic              report_first;
  logic [32:0]       stat_sum;

  assign frame_ready = (state == S_IDLE);

  always_comb begin
    timeout_hit  = 1'b0;
    report_first = 1'b0;
    stat_sum     = {1'b0, total_err_bits} + 33'(err_total);
    if (state == S_WAIT_DONE && !count_done_in && wc == WC_LAST) begin
      timeout_hit = 1'b1;
    end
    if (state == S_REPORT && rc == '0) begin
      report_first = 1'b1;
    end
  end

  // The shadow register shifts down one chunk per cycle and back-fills with ones, so
  // after the last real chunk it naturally supplies the all-ones (zero error) padding.
  always_ff @(posedge eval_clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      fs_q         <= 1'b0;
      start_pend   <= 1'b0;
      shadow       <= '1;
      sc           <= '0;
      wc           <= '0;
      rc           <= '0;
      en           <= 1'b0;
      hard_frame   <= '1;
      result_valid <= 1'b0;
      err_total    <= '0;
    end else begin
      fs_q       <= frame_start;
      start_pend <= frame_start & ~fs_q & (state == S_IDLE);
      case (state)
        S_IDLE: begin
          if (start_pend) begin
            shadow <= frame_in;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          en         <= 1'b1;
          hard_frame <= shadow[N-1:0];
          shadow     <= {{N{1'b1}}, shadow[VN_NUM-1:N]};
          sc         <= SC_W'(1);
          state      <= S_STREAM;
        end
        S_STREAM: begin
          if (sc == SC_LAST) begin
            en         <= 1'b0;
            hard_frame <= '1;
            wc         <= '0;
            state      <= S_WAIT_DONE;
          end else begin
            hard_frame <= shadow[N-1:0];
            shadow     <= {{N{1'b1}}, shadow[VN_NUM-1:N]};
            sc         <= sc + SC_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (count_done_in) begin
            err_total    <= err_count_in;
            result_valid <= 1'b1;
            rc           <= '0;
            state        <= S_REPORT;
          end else if (wc == WC_LAST) begin
            state <= S_IDLE;
          end else begin
            wc <= wc + WC_W'(1);
          end
        end
        S_REPORT: begin
          if (rc == RC_LAST) begin
            result_valid <= 1'b0;
            state        <= S_IDLE;
          end else begin
            rc <= rc + RC_W'(1);
          end
        end
        default: begin
          en           <= 1'b0;
          hard_frame   <= '1;
          result_valid <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

  // Clear takes priority over both the sticky timeout and the per-frame accumulation.
  always_ff @(posedge eval_clk or negedge rstn) begin
    if (!rstn) begin
      total_err_bits <= '0;
      err_frame_cnt  <= '0;
      timeout_err    <= 1'b0;
    end else if (clear_stats) begin
      total_err_bits <= '0;
      err_frame_cnt  <= '0;
      timeout_err    <= 1'b0;
    end else begin
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
      if (report_first) begin
        total_err_bits <= stat_sum[32] ? '1 : stat_sum[31:0];
        if (err_total != '0 && err_frame_cnt != 16'hFFFF) begin
          err_frame_cnt <= err_frame_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hard_frame_chunk_tx.sv
// Directed bench for hard_frame_chunk_tx with a cycle-timeline reference model and a
// behavioural stand-in for the error-bit counter.
module tb_hard_frame_chunk_tx;

  localparam int VN      = 7650;
  localparam int N       = 850;
  localparam int CHUNKS  = 9;
  localparam int EN_CYC  = 12;
  localparam int TIMEOUT = 64;
  localparam int SYN_LAT = 2;

  logic          eval_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          frame_start = 1'b0;
  logic          clear_stats = 1'b0;
  logic [VN-1:0] frame_in = '1;
  logic [N-1:0]  hard_frame;
  logic          en;
  logic [12:0]   err_count_in;
  logic          count_done_in;
  logic          frame_ready;
  logic          result_valid;
  logic [12:0]   err_total;
  logic [31:0]   total_err_bits;
  logic [15:0]   err_frame_cnt;
  logic          timeout_err;

  logic          ctr_done = 1'b0;
  logic          stim_done = 1'b0;
  logic          ctr_on = 1'b1;
  logic [12:0]   ctr_err = '0;

  assign count_done_in = ctr_done | stim_done;
  assign err_count_in  = stim_done ? 13'd77 : ctr_err;

  hard_frame_chunk_tx #(
    .VN_NUM(VN), .N(N), .ROW_CHUNK_NUM(CHUNKS), .PIPELINE_DEPTH(5),
    .SYN_LATENCY(SYN_LAT), .TIMEOUT(TIMEOUT), .ERR_BIT_BITWIDTH(13)
  ) dut (
    .eval_clk(eval_clk), .rstn(rstn), .frame_start(frame_start), .frame_in(frame_in),
    .clear_stats(clear_stats), .hard_frame(hard_frame), .en(en),
    .err_count_in(err_count_in), .count_done_in(count_done_in), .frame_ready(frame_ready),
    .result_valid(result_valid), .err_total(err_total), .total_err_bits(total_err_bits),
    .err_frame_cnt(err_frame_cnt), .timeout_err(timeout_err)
  );

  always #5 eval_clk = ~eval_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
  endtask

  // Counter stand-in: counts zero bits over the en window, answers with a 2-cycle done.
  int acc = 0;
  int hold = 0;
  logic prev_en = 1'b0;
  always @(negedge eval_clk or negedge rstn) begin
    if (!rstn) begin
      acc = 0; hold = 0; prev_en = 1'b0; ctr_done = 1'b0; ctr_err = '0;
    end else begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) ctr_done = 1'b0;
      end
      if (en) acc += $countones(~hard_frame);
      if (prev_en && !en) begin
        if (ctr_on) begin
          ctr_done = 1'b1;
          ctr_err  = 13'(acc);
          hold     = 2;
        end
        acc = 0;
      end
      prev_en = en;
    end
  end

  int en_hi = 0;
  int rv_hi = 0;
  always @(negedge eval_clk) begin
    if (en) en_hi++;
    if (result_valid) rv_hi++;
  end

  // Reference model: frame accepted at edge T drives en over edges T+2..T+13, done is
  // honoured on edges T+15..T+14+TIMEOUT, results are visible from the done edge D.
  bit            m_busy = 0, m_got = 0, m_end_known = 0, m_prev_fs = 0, m_timeout = 0;
  bit            rising;
  int            m_T = 0, m_D = 0, m_end = 0, m_upd_at = -1, m_frames = 0;
  longint        m_total = 0;
  logic [12:0]   m_err_total = '0;
  logic [VN-1:0] m_frame = '1;

  always @(posedge eval_clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 0; m_got = 0; m_end_known = 0; m_prev_fs = 0; m_timeout = 0;
      m_upd_at = -1; m_frames = 0; m_total = 0; m_err_total = '0;
    end else begin
      cyc++;
      rising    = frame_start && !m_prev_fs;
      m_prev_fs = frame_start;
      if (m_busy && m_end_known && cyc > m_end) m_busy = 0;
      if (!m_busy && rising) begin
        m_busy = 1; m_T = cyc; m_frame = frame_in; m_got = 0; m_end_known = 0; m_upd_at = -1;
      end else if (m_busy && !m_end_known && cyc >= m_T + 3 + EN_CYC && cyc <= m_T + 2 + EN_CYC + TIMEOUT) begin
        if (count_done_in) begin
          m_got = 1; m_D = cyc; m_err_total = err_count_in;
          m_end = cyc + SYN_LAT; m_end_known = 1; m_upd_at = cyc + 1;
        end else if (cyc == m_T + 2 + EN_CYC + TIMEOUT) begin
          m_timeout = 1; m_end = cyc; m_end_known = 1;
        end
      end
      if (cyc == m_upd_at) begin
        m_total = m_total + longint'(m_err_total);
        if (m_total > 64'hFFFF_FFFF) m_total = 64'hFFFF_FFFF;
        if (m_err_total != 0 && m_frames < 65535) m_frames++;
      end
      if (clear_stats) begin
        m_total = 0; m_frames = 0; m_timeout = 0;
      end
    end
  end

  logic         e_en, e_ready, e_rv;
  logic [N-1:0] e_hf;
  int           j;
  always @(negedge eval_clk) begin
    if (rstn && cyc > 0) begin
      j       = cyc - m_T - 2;
      e_en    = m_busy && j >= 0 && j < EN_CYC;
      e_hf    = '1;
      if (e_en && j < CHUNKS) e_hf = m_frame[j*N +: N];
      e_ready = !(m_busy && cyc >= m_T + 1 && (!m_end_known || cyc < m_end));
      e_rv    = m_got && cyc >= m_D && cyc < m_D + SYN_LAT;
      chk("en", 64'(en), 64'(e_en));
      chk("frame_ready", 64'(frame_ready), 64'(e_ready));
      chk("result_valid", 64'(result_valid), 64'(e_rv));
      chk("err_total", 64'(err_total), 64'(m_err_total));
      chk("total_err_bits", 64'(total_err_bits), 64'(m_total));
      chk("err_frame_cnt", 64'(err_frame_cnt), 64'(m_frames));
      chk("timeout_err", 64'(timeout_err), 64'(m_timeout));
      n_checks++;
      if (hard_frame === e_hf) n_pass++;
      else $display("FAIL hard_frame cyc=%0d got=%h exp=%h", cyc, hard_frame, e_hf);
    end
  end

  task automatic start_frame(input logic [VN-1:0] f);
    frame_in    = f;
    frame_start = 1'b1;
    @(negedge eval_clk);
    @(negedge eval_clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!frame_ready && k < 200) begin
      @(negedge eval_clk);
      k++;
    end
    chk("wait_ready", 64'(frame_ready), 64'd1);
  endtask

  logic [VN-1:0] f_ones, f_six, f_850;
  int en0, rv0, k;

  initial begin
    f_ones = '1;
    f_six  = '1;
    f_six[3*N + 0] = 1'b0;   f_six[3*N + 10] = 1'b0;  f_six[3*N + 100] = 1'b0;
    f_six[3*N + 500] = 1'b0; f_six[3*N + 849] = 1'b0; f_six[VN-1] = 1'b0;
    f_850  = '1;
    f_850[5*N +: N] = '0;

    repeat (3) @(negedge eval_clk);
    rstn = 1'b1;
    @(negedge eval_clk);
    chk("rst_en", 64'(en), 64'd0);
    chk("rst_hf_ones", 64'(&hard_frame), 64'd1);
    chk("rst_ready", 64'(frame_ready), 64'd1);
    chk("rst_rv", 64'(result_valid), 64'd0);
    chk("rst_err_total", 64'(err_total), 64'd0);
    chk("rst_total", 64'(total_err_bits), 64'd0);
    chk("rst_frames", 64'(err_frame_cnt), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);

    // clean frame
    en0 = en_hi; rv0 = rv_hi;
    start_frame(f_ones);
    wait_ready();
    chk("ones_en_cycles", 64'(en_hi - en0), 64'd12);
    chk("ones_rv_cycles", 64'(rv_hi - rv0), 64'd2);
    chk("ones_err_total", 64'(err_total), 64'd0);
    chk("ones_frames", 64'(err_frame_cnt), 64'd0);

    // six errors: five in chunk 3, one in the last bit
    start_frame(f_six);
    wait_ready();
    chk("six_err_total", 64'(err_total), 64'd6);
    chk("six_total", 64'(total_err_bits), 64'd6);
    chk("six_frames", 64'(err_frame_cnt), 64'd1);

    // back-to-back 6, 0, 850 after a clear
    clear_stats = 1'b1;
    @(negedge eval_clk);
    clear_stats = 1'b0;
    en0 = en_hi;
    start_frame(f_six);  wait_ready();
    start_frame(f_ones); wait_ready();
    start_frame(f_850);  wait_ready();
    chk("b2b_total", 64'(total_err_bits), 64'd856);
    chk("b2b_frames", 64'(err_frame_cnt), 64'd2);
    chk("b2b_err_total", 64'(err_total), 64'd850);
    chk("b2b_en_cycles", 64'(en_hi - en0), 64'd36);

    // counter silent -> timeout, then a good frame
    ctr_on = 1'b0;
    start_frame(f_six);
    wait_ready();
    chk("to_flag", 64'(timeout_err), 64'd1);
    chk("to_err_total_kept", 64'(err_total), 64'd850);
    chk("to_total_kept", 64'(total_err_bits), 64'd856);
    ctr_on = 1'b1;
    start_frame(f_ones);
    wait_ready();
    chk("after_to_err_total", 64'(err_total), 64'd0);
    chk("after_to_sticky", 64'(timeout_err), 64'd1);

    // re-pulse during STREAM and a stray done in IDLE are ignored
    en0 = en_hi; rv0 = rv_hi;
    start_frame(f_ones);
    repeat (4) @(negedge eval_clk);
    start_frame(f_850);
    wait_ready();
    stim_done = 1'b1;
    repeat (2) @(negedge eval_clk);
    stim_done = 1'b0;
    repeat (20) @(negedge eval_clk);
    chk("ign_en_cycles", 64'(en_hi - en0), 64'd12);
    chk("ign_rv_cycles", 64'(rv_hi - rv0), 64'd2);
    chk("ign_err_total", 64'(err_total), 64'd0);
    chk("ign_frames", 64'(err_frame_cnt), 64'd2);

    // reset in the 4th STREAM cycle
    start_frame(f_850);
    k = 0;
    while (!en && k < 20) begin
      @(negedge eval_clk);
      k++;
    end
    repeat (3) @(negedge eval_clk);
    chk("pre_rst_en", 64'(en), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_en", 64'(en), 64'd0);
    chk("mid_rst_ready", 64'(frame_ready), 64'd1);
    chk("mid_rst_hf_ones", 64'(&hard_frame), 64'd1);
    chk("mid_rst_total", 64'(total_err_bits), 64'd0);
    @(negedge eval_clk);
    rstn = 1'b1;
    @(negedge eval_clk);
    en0 = en_hi;
    start_frame(f_six);
    wait_ready();
    chk("post_rst_err_total", 64'(err_total), 64'd6);
    chk("post_rst_total", 64'(total_err_bits), 64'd6);
    chk("post_rst_en_cycles", 64'(en_hi - en0), 64'd12);

    // clear coinciding with the REPORT update
    start_frame(f_six);
    k = 0;
    while (!result_valid && k < 60) begin
      @(negedge eval_clk);
      k++;
    end
    chk("rv_seen", 64'(result_valid), 64'd1);
    clear_stats = 1'b1;
    @(negedge eval_clk);
    clear_stats = 1'b0;
    wait_ready();
    chk("clr_total", 64'(total_err_bits), 64'd0);
    chk("clr_frames", 64'(err_frame_cnt), 64'd0);
    chk("clr_err_total", 64'(err_total), 64'd6);

    repeat (5) @(negedge eval_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

endmodule
